mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_pkg.sv | 47 ++++
 rtl/mdu_arith.sv | 73 +++++++
 rtl/mdu_sequencer.sv | 122 ++++++++++++
 tb/tb_mdu_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies and FSM states.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are compiled only when the
// macro MDU_MADD_EN is defined; otherwise codes 7-10 decode as no-ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } md_op_e;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for several cycles.
  function automatic logic is_multicycle(logic [3:0] op);
    case (op)
      OpMult, OpMultu, OpDiv, OpDivu: return 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Counter load value; only meaningful when is_multicycle(op).
  function automatic logic [3:0] op_cycles(logic [3:0] op);
    case (op)
      OpDiv, OpDivu: return 4'(DIV_CYCLES);
      default:       return 4'(MULT_CYCLES);
    endcase
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide/accumulate datapath. wr_o is low when the op produces no
// result (unknown op, or a divide by zero, which must leave HI/LO untouched).
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  // Select the result for the latched op.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    wr_o = 1'b0;
    case (op_i)
      OpMult: begin
        {hi_o, lo_o} = prod_s;
        wr_o = 1'b1;
      end
      OpMultu: begin
        {hi_o, lo_o} = prod_u;
        wr_o = 1'b1;
      end
      OpDiv: begin
        if (b_i != 32'd0) begin
          lo_o = $signed(a_i) / $signed(b_i);
          hi_o = $signed(a_i) % $signed(b_i);
          wr_o = 1'b1;
        end
      end
      OpDivu: begin
        if (b_i != 32'd0) begin
          lo_o = a_i / b_i;
          hi_o = a_i % b_i;
          wr_o = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      OpMadd: begin
        {hi_o, lo_o} = {hi_i, lo_i} + prod_s;
        wr_o = 1'b1;
      end
      OpMaddu: begin
        {hi_o, lo_o} = {hi_i, lo_i} + prod_u;
        wr_o = 1'b1;
      end
      OpMsub: begin
        {hi_o, lo_o} = {hi_i, lo_i} - prod_s;
        wr_o = 1'b1;
      end
      OpMsubu: begin
        {hi_o, lo_o} = {hi_i, lo_i} - prod_u;
        wr_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multicycle MDU sequencer: IDLE/RUN FSM, cycle counter and architectural HI/LO.
// Operands are latched at start, the result is parked in pending registers while running
// and committed on the edge that leaves RUN. Accumulate ops need MDU_MADD_EN.
module mdu_sequencer
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .wr_o (res_wr)
  );

  // Next-state: accept ops in IDLE, count down in RUN, commit on the last RUN cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_multicycle(md_op)) begin
            state_d   = StRun;
            cnt_d     = op_cycles(md_op);
            op_d      = md_op;
            a_d       = A;
            b_d       = B;
            pend_wr_d = 1'b0;
          end else if (md_op == OpMthi) begin
            hi_d = A;
          end else if (md_op == OpMtlo) begin
            lo_d = A;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q > 4'd1) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = res_wr;
        end else begin
          state_d = StIdle;
          // Divide by zero leaves pend_wr_q low, so HI/LO keep their old values.
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      op_q      <= 4'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign md_stall = d_is_md & (busy | (start & is_multicycle(md_op)));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus random ops checked
// against an arithmetic reference model. Define MDU_MADD_EN to also exercise accumulate ops.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, d_is_md;
  logic [3:0]  md_op;
  logic [31:0] A, B, HI, LO;
  logic        busy, md_stall;

  int compared   = 0;
  int mismatched = 0;

  // Reference HI/LO.
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .md_stall (md_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Latency of an op, straight from the op table; 0 means single-edge or no-op.
  function automatic int op_latency(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return 5;
      4'd3, 4'd4: return 10;
`ifdef MDU_MADD_EN
      4'd7, 4'd8, 4'd9, 4'd10: return 5;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural effect of one op on the reference HI/LO.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] acc, p;
    int          ia, ib;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = a;
    ib  = b;
    acc = {m_hi, m_lo};
    case (op)
      4'd1: {m_hi, m_lo} = sa * sb;
      4'd2: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      4'd3: if (b != 0) begin m_lo = ia / ib; m_hi = ia % ib; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
`ifdef MDU_MADD_EN
      4'd7:  {m_hi, m_lo} = acc + 64'(sa * sb);
      4'd8:  {m_hi, m_lo} = acc + {32'b0, a} * {32'b0, b};
      4'd9:  {m_hi, m_lo} = acc - 64'(sa * sb);
      4'd10: {m_hi, m_lo} = acc - {32'b0, a} * {32'b0, b};
`endif
      default: ;
    endcase
  endtask

  // Issue one op and check busy/md_stall/HI/LO every cycle until it completes.
  // With glitch set, a second start (div) is pulsed mid-run and must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic glitch);
    int n;
    n       = op_latency(op);
    start   = 1'b1;
    md_op   = op;
    A       = a;
    B       = b;
    d_is_md = dmd;
    #1;
    check("stall_at_start", {31'b0, md_stall}, {31'b0, dmd && (n != 0)});
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 4'd0;
    A     = $urandom;
    B     = $urandom;
    for (int i = 0; i < n; i++) begin
      check("busy_run", {31'b0, busy}, 32'd1);
      check("stall_run", {31'b0, md_stall}, {31'b0, dmd});
      check("hi_hold", HI, m_hi);
      check("lo_hold", LO, m_lo);
      if (glitch && i == 1) begin
        start = 1'b1;
        md_op = 4'd3;
        B     = 32'd3;
      end else begin
        start = 1'b0;
        md_op = 4'd0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    md_op = 4'd0;
    model_apply(op, a, b);
    #1;
    check("busy_done", {31'b0, busy}, 32'd0);
    check("stall_done", {31'b0, md_stall}, 32'd0);
    check("hi_result", HI, m_hi);
    check("lo_result", LO, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset   = 1'b1;
    start   = 1'b1;
    md_op   = 4'd1;
    A       = 32'd7;
    B       = 32'd9;
    d_is_md = 1'b0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;

    // Reset wins over a simultaneous start.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    md_op = 4'd0;
    d_is_md = 1'b1;
    #1;
    check("reset_stall", {31'b0, md_stall}, 32'd0);

    // Directed corner cases.
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    check("mult_m1x2_hi", HI, 32'hFFFF_FFFF);
    check("mult_m1x2_lo", LO, 32'hFFFF_FFFE);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("div_m7_2_lo", LO, 32'hFFFF_FFFD);
    check("div_m7_2_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu_by0_lo", LO, 32'hFFFF_FFFD);
    check("divu_by0_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd6, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
    check("mtlo_lo", LO, 32'h0000_1234);
    run_op(4'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op(4'd13, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);

    // Reset in the third busy cycle of a mult aborts with no later commit.
    start = 1'b1;
    md_op = 4'd1;
    A     = 32'd3;
    B     = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    md_op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_commit_hi", HI, 32'd0);
    check("abort_no_commit_lo", LO, 32'd0);
    check("abort_no_busy", {31'b0, busy}, 32'd0);

`ifdef MDU_MADD_EN
    run_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    run_op(4'd8, 32'd1, 32'd1, 1'b1, 1'b0);
    check("maddu_carry_hi", HI, 32'd1);
    check("maddu_carry_lo", LO, 32'd0);
`endif

    // Random ops, including no-ops, undefined codes and divide by zero.
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(op, a, b, 1'($urandom_range(0, 1)),
             1'(op_latency(op) != 0 && $urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
